// File: rtl/evm_ballot_ctrl.sv
// EVM ballot sequencer: debounces the officer/voter buttons, enables one ballot per
// issue, validates the party switch and strobes a single vote to the counters.
module evm_ballot_ctrl #(
  parameter int DEB_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int HOLD_CYCLES    = 200,
  parameter int MAX_BALLOTS    = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll_en,
  input  logic       issue_btn,
  input  logic       cast_btn,
  input  logic [2:0] voter_switch,
  output logic       ballot_en,
  output logic       cast_valid,
  output logic [2:0] cast_sel,
  output logic       invalid,
  output logic       reject,
  output logic       timeout,
  output logic       busy,
  output logic       full,
  output logic [6:0] issued_cnt
);

  localparam int CW    = $clog2(DEB_CYCLES + 1);
  localparam int TMAX  = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {CLOSED, IDLE, BALLOT, COMMIT, HOLD} state_t;

  logic [1:0] btn_raw;
  logic [1:0] btn_rise;
  logic       issue_rise;
  logic       cast_rise;

  assign btn_raw    = {cast_btn, issue_btn};
  assign issue_rise = btn_rise[0];
  assign cast_rise  = btn_rise[1];

  // Each button: 2-flop sync, then the synced level must differ from the accepted
  // level for DEB_CYCLES consecutive cycles before it is taken.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic          s1_reg;
      logic          s2_reg;
      logic          deb_reg;
      logic          rise_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          deb_reg  <= 1'b0;
          rise_reg <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          s1_reg   <= btn_raw[gi];
          s2_reg   <= s1_reg;
          rise_reg <= 1'b0;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
            cnt_reg  <= '0;
            deb_reg  <= s2_reg;
            rise_reg <= s2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign btn_rise[gi] = rise_reg;
    end
  endgenerate

  logic [2:0]    sw_s1_reg;
  logic [2:0]    sw_s2_reg;
  logic          sw_onehot;
  logic          sw_bad;
  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [6:0]    issued_cnt_reg;
  logic          ballot_en_reg;
  logic          cast_valid_reg;
  logic [2:0]    cast_sel_reg;
  logic          invalid_reg;
  logic          reject_reg;
  logic          timeout_reg;
  logic          busy_reg;
  logic          full_w;

  assign sw_onehot = (sw_s2_reg == 3'b001) || (sw_s2_reg == 3'b010) || (sw_s2_reg == 3'b100);
  assign sw_bad    = !sw_onehot && (sw_s2_reg != 3'b000);
  assign full_w    = (issued_cnt_reg == 7'(MAX_BALLOTS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_reg      <= 3'b000;
      sw_s2_reg      <= 3'b000;
      state_reg      <= CLOSED;
      timer_reg      <= '0;
      issued_cnt_reg <= '0;
      ballot_en_reg  <= 1'b0;
      cast_valid_reg <= 1'b0;
      cast_sel_reg   <= 3'b000;
      invalid_reg    <= 1'b0;
      reject_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      sw_s1_reg      <= voter_switch;
      sw_s2_reg      <= sw_s1_reg;
      cast_valid_reg <= 1'b0;
      cast_sel_reg   <= 3'b000;
      reject_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      if (!poll_en) begin
        // Closing voids any open ballot silently; a strobe already on the wire completes.
        state_reg     <= CLOSED;
        ballot_en_reg <= 1'b0;
        invalid_reg   <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          CLOSED: state_reg <= IDLE;
          IDLE: begin
            if (issue_rise && !full_w) begin
              state_reg     <= BALLOT;
              timer_reg     <= TW'(TIMEOUT_CYCLES - 1);
              ballot_en_reg <= 1'b1;
              invalid_reg   <= sw_bad;
            end
          end
          BALLOT: begin
            if (cast_rise && sw_onehot) begin
              state_reg      <= COMMIT;
              cast_valid_reg <= 1'b1;
              cast_sel_reg   <= sw_s2_reg;
              ballot_en_reg  <= 1'b0;
              invalid_reg    <= 1'b0;
              if (!full_w) issued_cnt_reg <= issued_cnt_reg + 1'b1;
            end else if (timer_reg == '0) begin
              state_reg     <= IDLE;
              timeout_reg   <= 1'b1;
              ballot_en_reg <= 1'b0;
              invalid_reg   <= 1'b0;
              reject_reg    <= cast_rise;
            end else begin
              timer_reg   <= timer_reg - 1'b1;
              invalid_reg <= sw_bad;
              reject_reg  <= cast_rise;
            end
          end
          COMMIT: begin
            state_reg <= HOLD;
            timer_reg <= TW'(HOLD_CYCLES - 1);
            busy_reg  <= 1'b1;
          end
          HOLD: begin
            if (timer_reg == '0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          default: state_reg <= CLOSED;
        endcase
      end
    end
  end

  assign ballot_en  = ballot_en_reg;
  assign cast_valid = cast_valid_reg;
  assign cast_sel   = cast_sel_reg;
  assign invalid    = invalid_reg;
  assign reject     = reject_reg;
  assign timeout    = timeout_reg;
  assign busy       = busy_reg;
  assign full       = full_w;
  assign issued_cnt = issued_cnt_reg;

endmodule
